// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: debug initiator that halts the CPU and streams out every register-file entry.
//
// Operation: on start, asserts cpu_halt and waits HALT_WAIT cycles so any
// in-flight write can retire. It then sweeps rf_read_reg over the registers.
// Each value is captured in a READ cycle and offered in a SEND cycle over
// out_valid/out_ready. abort cancels a dump at any time.
//
// Ports:
//   clk, rstn       clock; asynchronous active-low reset
//   start, abort    dump request (sampled in IDLE) / synchronous cancel
//   cpu_halt        datapath freeze, high whenever not IDLE
//   rf_read_reg     register-file read address
//   rf_read_data    combinational read data for rf_read_reg
//   out_valid/out_ready/out_data/out_addr/out_last  output stream
//   busy, done      activity flag / one-cycle completion pulse
//
// Optional feature: REG_DUMP_SKIP_ZERO_EN. When it is defined, register 0 is
// skipped and the sweep starts at address 1.
module reg_dump_ctrl #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int HALT_WAIT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [31:0]       rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    READ,
    SEND,
    DONE
  } state_e;

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [3:0]        WAIT_INIT = 4'(HALT_WAIT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         wait_q, wait_d;
  logic [31:0]        data_q, data_d;
  logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
  logic               last_q, last_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    data_d  = data_q;
    oaddr_d = oaddr_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          state_d = HALT;
          wait_d  = WAIT_INIT;
        end
      end
      HALT: begin
        if (wait_q == '0) begin
          state_d = READ;
          addr_d  = FIRST_ADDR;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      READ: begin
        data_d  = rf_read_data;
        oaddr_d = addr_q;
        last_d  = (addr_q == LAST_ADDR);
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase

    // abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      oaddr_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      oaddr_q <= oaddr_d;
      last_q  <= last_d;
    end
  end

  assign cpu_halt    = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == SEND);
  assign done        = (state_q == DONE);
  assign rf_read_reg = addr_q;
  assign out_data    = data_q;
  assign out_addr    = oaddr_q;
  assign out_last    = last_q;

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Debug initiator for the 32×32 register file: on request it freezes the datapath, sweeps the register file's read port through every register address, and streams each captured value out over a valid/ready interface. It sits beside the register file, driving one read-address port and consuming the matching read-data bus. It is the read-side counterpart of the register file's responder role, feeding a debug/trace sink.

## Interface
- NUM_REGS, 32: registers swept, addresses 0..NUM_REGS-1.
- ADDR_W, 5: register address width.
- HALT_WAIT, 2: cycles between halt assertion and the first read, so any in-flight write can retire; legal range 1..15.
- clk  input  1  clock; all state changes on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; takes priority over every other input except rstn.
- cpu_halt  output  1  freezes the datapath, so no register-file writes occur while high.
- rf_read_reg  output  ADDR_W  address driven onto the register-file read port.
- rf_read_data  input  32  combinational read data for rf_read_reg.
- out_valid  output  1  out_data, out_addr and out_last are valid.
- out_ready  input  1  the sink accepts the beat on a cycle with out_valid & out_ready.
- out_data  output  32  captured register value.
- out_addr  output  ADDR_W  address of out_data.
- out_last  output  1  high on the final beat of a dump.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a dump completes normally.

## Operation
- FSM states are IDLE, HALT, READ, SEND and DONE. Reset enters IDLE with addr=0 and wait counter=0.
- IDLE: on start, go to HALT and load the wait counter with HALT_WAIT-1.
- HALT: cpu_halt=1. Decrement the counter each cycle. When it reaches 0, go to READ with addr = first address.
- READ: rf_read_reg=addr. At the clock edge, capture rf_read_data into out_data and addr into out_addr. Set out_last = (addr==NUM_REGS-1), then go to SEND.
- SEND: out_valid=1, and the outputs stay stable until the beat is accepted. On acceptance:
  - if out_last, go to DONE;
  - otherwise increment addr and go to READ.
- DONE: done=1 for exactly one cycle, then go to IDLE. cpu_halt drops on the edge leaving DONE.
- cpu_halt=1 in HALT, READ, SEND and DONE, and 0 in IDLE.
- rf_read_reg = addr in every state, and addr = 0 in IDLE.
- start outside IDLE is ignored.
- abort in any non-IDLE state: next state is IDLE, addr is cleared and out_valid drops. This is the only case where out_valid may fall without acceptance. No done pulse is generated.
- start and abort together in IDLE: abort wins and the FSM stays in IDLE.
- addr never wraps, because the sweep ends at NUM_REGS-1.

## Timing
- Reset values: cpu_halt=0, rf_read_reg=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0. All apply asynchronously on rstn low.
- A reset mid-dump takes effect immediately: cpu_halt and out_valid drop with no further beats.
- start sampled at edge T gives busy=1 and cpu_halt=1 after T. The first READ cycle is HALT_WAIT cycles later.
- Each beat takes 2 cycles (READ + SEND) with out_ready held high, so a full sweep with out_ready=1 is 1 + HALT_WAIT + 2·NUM_REGS + 1 cycles from start to IDLE.
- Backpressure stretches SEND only. Data captured in READ is never re-read.

## Configuration
- REG_DUMP_SKIP_ZERO_EN defined: the first address is 1. Register 0 is never read or sent, a dump is NUM_REGS-1 beats, and out_addr never equals 0.
- Undefined: the first address is 0 and a dump is NUM_REGS beats. Register 0 is streamed as whatever rf_read_data returns, expected 0.

## Test plan
- Reset, then preload register k = 32'hA5A5_0000+k, then pulse start with out_ready=1.
  - Required: 32 beats (31 if skip-zero is enabled), out_addr ascending and out_data matching each preload.
  - Required: out_last only on addr 31, then one done pulse. cpu_halt spans start+1 through DONE.
- Randomly toggle out_ready during a dump. Required: out_data and out_addr stay stable while valid & !ready, with no lost or duplicated beats.
- Assert abort during the SEND of addr 10. Required: next cycle is IDLE, with out_valid=0, cpu_halt=0, busy=0, no done pulse and rf_read_reg=0.
- Drop rstn in the middle of HALT. Required: all outputs go to their reset values before the next clock edge, and after release start begins a fresh dump from the first address.
- Pulse start while busy at addr 5, and pulse start+abort together in IDLE.
  - Required: the in-progress dump is unaffected by the stray start.
  - Required: the FSM stays in IDLE for the start+abort case.
- Set HALT_WAIT=1, assert start and count cycles. Required: the first READ is 1 cycle after entering HALT, and the total is 67 cycles with out_ready=1 and skip-zero disabled.
